// File: rtl/cmp_stream_tracker_if.sv
`default_nettype none
// ============================================================================
// Module : cmp_stream_tracker_if
// Brief  : Handshake, operand, result and statistics bundle for cmp_stream_tracker.
// Rev    : 1.0  initial release
// ============================================================================
interface cmp_stream_tracker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             greater;
  logic             lower;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [CNT_W-1:0] sample_cnt;
  logic             stats_valid;

  // Source/consumer side
  modport master (
    output in_valid, a, b, signed_mode, clear, out_ready,
    input  in_ready, out_valid, equal, greater, lower,
           max_val, min_val, sample_cnt, stats_valid
  );

  // Tracker side
  modport slave (
    input  in_valid, a, b, signed_mode, clear, out_ready,
    output in_ready, out_valid, equal, greater, lower,
           max_val, min_val, sample_cnt, stats_valid
  );
endinterface
`default_nettype wire

// File: rtl/cmp_stream_tracker.sv
`default_nettype none
// ============================================================================
// Module : cmp_stream_tracker
// Brief  : Streaming signed/unsigned comparator with registered result and
//          running min/max/count statistics of operand a.
// Rev    : 1.0  initial release
// ============================================================================
module cmp_stream_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_stream_tracker_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // Returns {equal, greater, lower}; the extra bit makes the difference exact.
  function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic             sm);
    logic [WIDTH:0] xe;
    logic [WIDTH:0] ye;
    logic [WIDTH:0] d;
    logic [2:0]     r;
    xe   = {sm & x[WIDTH-1], x};
    ye   = {sm & y[WIDTH-1], y};
    d    = xe - ye;
    r[2] = (d == '0);
    r[0] = d[WIDTH];
    r[1] = !r[2] && !d[WIDTH];
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [2:0]       flags_q,     flags_d;
  state_t           state_q,     state_d;
  logic             mode_q,      mode_d;
  logic [WIDTH-1:0] max_q,       max_d;
  logic [WIDTH-1:0] min_q,       min_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic       w_in_ready;
  logic       w_xfer_in;
  logic       w_xfer_out;
  logic       w_restart;
  logic [2:0] w_vs_max;
  logic [2:0] w_vs_min;

  assign w_in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign w_xfer_in  = bus.in_valid && w_in_ready;
  assign w_xfer_out = out_valid_q && bus.out_ready;

  assign w_restart  = w_xfer_in && ((state_q == ST_EMPTY) || bus.clear ||
                                    (bus.signed_mode != mode_q));
  assign w_vs_max   = cmp3(bus.a, max_q, mode_q);
  assign w_vs_min   = cmp3(bus.a, min_q, mode_q);

  always_comb begin
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    if (w_xfer_in) begin
      out_valid_d = 1'b1;
      flags_d     = cmp3(bus.a, bus.b, bus.signed_mode);
    end else if (w_xfer_out) begin
      out_valid_d = 1'b0;
      flags_d     = 3'b000;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    if (w_restart) begin
      state_d = ST_TRACK;
      mode_d  = bus.signed_mode;
      max_d   = bus.a;
      min_d   = bus.a;
      cnt_d   = C_CNT_ONE;
    end else if (w_xfer_in) begin
      // Extremes keep tracking even once the counter has saturated.
      if (w_vs_max[1]) max_d = bus.a;
      if (w_vs_min[0]) min_d = bus.a;
      if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + C_CNT_ONE;
    end else if (bus.clear) begin
      state_d = ST_EMPTY;
      max_d   = '0;
      min_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      flags_q     <= 3'b000;
      state_q     <= ST_EMPTY;
      mode_q      <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      max_q       <= max_d;
      min_q       <= min_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.equal       = flags_q[2];
  assign bus.greater     = flags_q[1];
  assign bus.lower       = flags_q[0];
  assign bus.max_val     = max_q;
  assign bus.min_val     = min_q;
  assign bus.sample_cnt  = cnt_q;
  assign bus.stats_valid = (state_q == ST_TRACK);

endmodule
`default_nettype wire

// File: tb/tb_cmp_stream_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_cmp_stream_tracker
// Brief  : Directed table-driven bench for cmp_stream_tracker (CNT_W=16 and 2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cmp_stream_tracker;

  localparam logic [2:0] F_NO = 3'b000;
  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;
  localparam int         NV   = 23;

  typedef struct {
    logic        iv;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic        clr;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [2:0]  exp_f;
    logic [7:0]  exp_max;
    logic [7:0]  exp_min;
    logic [15:0] exp_cnt;
    logic        exp_sv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  cmp_stream_tracker_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  cmp_stream_tracker_if #(.WIDTH(8), .CNT_W(2))  bus1 ();

  cmp_stream_tracker #(.WIDTH(8), .CNT_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  cmp_stream_tracker #(.WIDTH(8), .CNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  function automatic vec_t mk(logic iv, logic [7:0] a, logic [7:0] b, logic sm,
                              logic clr, logic ordy, logic rdy, logic ov,
                              logic [2:0] f, logic [7:0] mx, logic [7:0] mn,
                              int cnt, logic sv);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.sm = sm; v.clr = clr; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_f = f; v.exp_max = mx;
    v.exp_min = mn; v.exp_cnt = 16'(cnt); v.exp_sv = sv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out0(input string tag, input logic ov, input logic [2:0] f,
                          input logic [7:0] mx, input logic [7:0] mn,
                          input logic [15:0] cnt, input logic sv);
    chk({tag, ".out_valid"},   32'(bus0.out_valid), 32'(ov));
    chk({tag, ".flags"},       32'({bus0.equal, bus0.greater, bus0.lower}), 32'(f));
    chk({tag, ".max_val"},     32'(bus0.max_val), 32'(mx));
    chk({tag, ".min_val"},     32'(bus0.min_val), 32'(mn));
    chk({tag, ".sample_cnt"},  32'(bus0.sample_cnt), 32'(cnt));
    chk({tag, ".stats_valid"}, 32'(bus0.stats_valid), 32'(sv));
  endtask

  task automatic drive0(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic clr, input logic ordy);
    bus0.in_valid = iv; bus0.a = a; bus0.b = b;
    bus0.signed_mode = sm; bus0.clear = clr; bus0.out_ready = ordy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sat_a   [5];
    logic [1:0]  sat_cnt [5];

    //            iv a      b      sm clr rdy | rdy ov flags max    min    cnt sv
    tbl[0]  = mk(1, 8'h80, 8'h01, 1, 0, 1,   1,  1, F_LT, 8'h80, 8'h80, 1, 1);
    tbl[1]  = mk(1, 8'h80, 8'h01, 0, 0, 1,   1,  1, F_GT, 8'h80, 8'h80, 1, 1);
    tbl[2]  = mk(1, 8'h7F, 8'h7F, 0, 0, 1,   1,  1, F_EQ, 8'h80, 8'h7F, 2, 1);
    tbl[3]  = mk(1, 8'h7F, 8'h80, 1, 0, 1,   1,  1, F_GT, 8'h7F, 8'h7F, 1, 1);
    tbl[4]  = mk(0, 8'h00, 8'h00, 0, 1, 1,   1,  0, F_NO, 8'h00, 8'h00, 0, 0);
    tbl[5]  = mk(1, 8'h05, 8'h05, 1, 0, 1,   1,  1, F_EQ, 8'h05, 8'h05, 1, 1);
    tbl[6]  = mk(1, 8'hFD, 8'h00, 1, 0, 1,   1,  1, F_LT, 8'h05, 8'hFD, 2, 1);
    tbl[7]  = mk(1, 8'h64, 8'h70, 1, 0, 1,   1,  1, F_LT, 8'h64, 8'hFD, 3, 1);
    tbl[8]  = mk(1, 8'h00, 8'hFF, 1, 0, 1,   1,  1, F_GT, 8'h64, 8'hFD, 4, 1);
    tbl[9]  = mk(1, 8'h10, 8'h10, 0, 0, 1,   1,  1, F_EQ, 8'h10, 8'h10, 1, 1);
    tbl[10] = mk(1, 8'h22, 8'h30, 0, 1, 1,   1,  1, F_LT, 8'h22, 8'h22, 1, 1);
    tbl[11] = mk(1, 8'h01, 8'hFF, 0, 0, 1,   1,  1, F_LT, 8'h22, 8'h01, 2, 1);
    tbl[12] = mk(1, 8'h90, 8'h10, 0, 0, 1,   1,  1, F_GT, 8'h90, 8'h01, 3, 1);
    tbl[13] = mk(1, 8'h05, 8'h05, 0, 0, 0,   0,  1, F_GT, 8'h90, 8'h01, 3, 1);
    tbl[14] = mk(1, 8'h05, 8'h05, 0, 0, 0,   0,  1, F_GT, 8'h90, 8'h01, 3, 1);
    tbl[15] = mk(1, 8'h05, 8'h05, 0, 0, 1,   1,  1, F_EQ, 8'h90, 8'h01, 4, 1);
    tbl[16] = mk(1, 8'h03, 8'h07, 0, 0, 1,   1,  1, F_LT, 8'h90, 8'h01, 5, 1);
    tbl[17] = mk(0, 8'h00, 8'h00, 0, 1, 0,   0,  1, F_LT, 8'h00, 8'h00, 0, 0);
    tbl[18] = mk(0, 8'h00, 8'h00, 0, 0, 1,   1,  0, F_NO, 8'h00, 8'h00, 0, 0);
    tbl[19] = mk(1, 8'h02, 8'h01, 0, 1, 0,   1,  1, F_GT, 8'h02, 8'h02, 1, 1);
    tbl[20] = mk(1, 8'h03, 8'h01, 0, 0, 1,   1,  1, F_GT, 8'h03, 8'h02, 2, 1);
    tbl[21] = mk(1, 8'h04, 8'h09, 0, 0, 1,   1,  1, F_LT, 8'h04, 8'h02, 3, 1);
    tbl[22] = mk(0, 8'h00, 8'h00, 0, 0, 1,   1,  0, F_NO, 8'h04, 8'h02, 3, 1);

    sat_a   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9};
    sat_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    bus1.in_valid = 1'b0; bus1.a = 8'h00; bus1.b = 8'h00;
    bus1.signed_mode = 1'b0; bus1.clear = 1'b0; bus1.out_ready = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset.in_ready", 32'(bus0.in_ready), 32'd0);
    chk_out0("reset", 1'b0, F_NO, 8'h00, 8'h00, 16'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive0(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].clr, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(bus0.in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk_out0($sformatf("v%0d", i), tbl[i].exp_ov, tbl[i].exp_f, tbl[i].exp_max,
               tbl[i].exp_min, tbl[i].exp_cnt, tbl[i].exp_sv);
    end

    // Rebuild a pending result (ov=1, cnt=4) then reset over it
    drive0(1'b1, 8'h06, 8'h01, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_out0("pre_rst", 1'b1, F_GT, 8'h06, 8'h02, 16'd4, 1'b1);
    drive0(1'b1, 8'h55, 8'h01, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst.in_ready", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    chk_out0("mid_rst", 1'b0, F_NO, 8'h00, 8'h00, 16'd0, 1'b0);
    rst = 1'b0;
    drive0(1'b1, 8'h07, 8'h07, 1'b0, 1'b0, 1'b1);
    #1;
    chk("post_rst.in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;
    chk_out0("post_rst", 1'b1, F_EQ, 8'h07, 8'h07, 16'd1, 1'b1);
    drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Counter saturation with CNT_W=2
    for (int k = 0; k < 5; k++) begin
      bus1.in_valid = 1'b1; bus1.a = sat_a[k]; bus1.b = 8'h00;
      @(posedge clk); #1;
      chk($sformatf("sat%0d.sample_cnt", k), 32'(bus1.sample_cnt), 32'(sat_cnt[k]));
      chk($sformatf("sat%0d.max_val", k), 32'(bus1.max_val), 32'(sat_a[k]));
    end
    bus1.in_valid = 1'b0;
    chk("sat.min_val", 32'(bus1.min_val), 32'd1);
    chk("sat.greater", 32'(bus1.greater), 32'd1);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
